// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD datapath and its controller: ALU opcodes,
// write-data source encodings and a small opcode classification helper.
package gcd_pkg;

  // ALU operation codes; values 8..15 are reserved and yield a zero result.
  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLTU  = 4'd5,
    ALU_PASSA = 4'd6,
    ALU_PASSB = 4'd7
  } alu_op_e;

  // Write-data source select encodings.
  localparam logic WDSRC_ALU   = 1'b0;
  localparam logic WDSRC_CONST = 1'b1;

  // True for the opcodes that produce a carry or borrow.
  function automatic logic is_arith(input logic [3:0] func);
    return (func == ALU_ADD) || (func == ALU_SUB);
  endfunction

endpackage

// File: rtl/gcd_alu.sv
// Combinational ALU for the GCD datapath. Produces the result word plus the
// raw add carry-out and the unsigned A<B flag (which doubles as SUB borrow).
module gcd_alu
  import gcd_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  input  logic [3:0]    i_func,
  output logic [DW-1:0] o_result,
  output logic          o_carry_add,
  output logic          o_lt
);

  logic [DW:0]   w_sum;
  logic [DW-1:0] w_diff;

  assign w_sum       = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff      = i_a - i_b;
  assign o_carry_add = w_sum[DW];
  assign o_lt        = (i_a < i_b);

  // Result selection by opcode; reserved opcodes fall through to zero.
  always_comb begin
    // NOTE: default assigned before the case so no path leaves o_result
    // unassigned, which would otherwise infer a latch.
    o_result = '0;
    case (i_func)
      ALU_ADD:   o_result = w_sum[DW-1:0];
      ALU_SUB:   o_result = w_diff;
      ALU_AND:   o_result = i_a & i_b;
      ALU_OR:    o_result = i_a | i_b;
      ALU_XOR:   o_result = i_a ^ i_b;
      ALU_SLTU:  o_result = {{(DW-1){1'b0}}, o_lt};
      ALU_PASSA: o_result = i_a;
      ALU_PASSB: o_result = i_b;
      default:   o_result = '0;
    endcase
  end

endmodule

// File: rtl/gcd_datapath.sv
// GCD datapath: NREG x DW register file with two combinational operand read
// ports and one debug read port, a write mux between ALU result and a
// controller constant, and a carry flag captured on written ADD/SUB.
// Status flags (isZero, aLtB) are purely combinational so the controller can
// branch in the same cycle it presents the read addresses.
module gcd_datapath
  import gcd_pkg::*;
#(
  parameter int DW   = 32,
  parameter int NREG = 16,
  parameter int AW   = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] raddr1,
  input  logic [AW-1:0] raddr2,
  input  logic          wen,
  input  logic [AW-1:0] waddr,
  input  logic          wdsrc,
  input  logic [3:0]    func,
  input  logic [DW-1:0] constant,
  output logic          isZero,
  output logic          aLtB,
  output logic          carry,
  input  logic [AW-1:0] dbg_raddr,
  output logic [DW-1:0] dbg_rdata
);

  logic [DW-1:0] r_regs [NREG];
  logic          r_carry;

  logic [DW-1:0] w_a;
  logic [DW-1:0] w_b;
  logic [DW-1:0] w_result;
  logic [DW-1:0] w_wdata;
  logic          w_carry_add;
  logic          w_lt;

  // Unbypassed reads: a same-cycle write is only visible after the edge.
  assign w_a       = r_regs[raddr1];
  assign w_b       = r_regs[raddr2];
  assign dbg_rdata = r_regs[dbg_raddr];

  gcd_alu #(.DW(DW)) u_alu (
    .i_a         (w_a),
    .i_b         (w_b),
    .i_func      (func),
    .o_result    (w_result),
    .o_carry_add (w_carry_add),
    .o_lt        (w_lt)
  );

  assign w_wdata = (wdsrc == WDSRC_CONST) ? constant : w_result;
  assign isZero  = (w_result == '0);
  assign aLtB    = w_lt;
  assign carry   = r_carry;

  // Register file write port; every entry clears while reset is held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the register file is reset entry by entry because the
      // controller relies on all-zero contents after reset; this forces
      // flops rather than a RAM macro, which is acceptable at this size.
      for (int i = 0; i < NREG; i++) begin
        // NOTE: non-blocking assignment for all sequential state so every
        // flop samples pre-edge values regardless of statement order.
        r_regs[i] <= '0;
      end
    end else if (wen) begin
      r_regs[waddr] <= w_wdata;
    end
  end

  // Carry flag: captured only on a written ADD/SUB sourced from the ALU.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_carry <= 1'b0;
    end else if (wen && (wdsrc == WDSRC_ALU) && is_arith(func)) begin
      r_carry <= (func == ALU_ADD) ? w_carry_add : w_lt;
    end
  end

endmodule

// File: tb/tb_gcd_datapath.sv
// Self-checking bench for gcd_datapath: directed scenarios with literal
// expectations followed by randomized traffic, all compared every cycle
// against a behavioural model of the register file and flags.
module tb_gcd_datapath;

  localparam int DW   = 32;
  localparam int NREG = 16;
  localparam int AW   = 4;

  logic          clk;
  logic          rst;
  logic [AW-1:0] raddr1, raddr2, waddr, dbg_raddr;
  logic          wen, wdsrc;
  logic [3:0]    func;
  logic [DW-1:0] constant;
  logic          isZero, aLtB, carry;
  logic [DW-1:0] dbg_rdata;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 0;

  gcd_datapath #(.DW(DW), .NREG(NREG), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .raddr1    (raddr1),
    .raddr2    (raddr2),
    .wen       (wen),
    .waddr     (waddr),
    .wdsrc     (wdsrc),
    .func      (func),
    .constant  (constant),
    .isZero    (isZero),
    .aLtB      (aLtB),
    .carry     (carry),
    .dbg_raddr (dbg_raddr),
    .dbg_rdata (dbg_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DW-1:0] m_regs [NREG];
  logic          m_carry;

  function automatic logic [DW-1:0] model_alu(input int f, input longint a,
                                              input longint b);
    longint r;
    case (f)
      0: r = (a + b) % 64'h1_0000_0000;
      1: r = (a - b + 64'h1_0000_0000) % 64'h1_0000_0000;
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = (a < b) ? 1 : 0;
      6: r = a;
      7: r = b;
      default: r = 0;
    endcase
    return r[DW-1:0];
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) m_regs[i] = '0;
      m_carry = 1'b0;
    end else if (wen) begin
      longint a, b;
      a = m_regs[raddr1];
      b = m_regs[raddr2];
      if (wdsrc) begin
        m_regs[waddr] = constant;
      end else begin
        if (func == 4'd0) m_carry = ((a + b) >= 64'h1_0000_0000);
        if (func == 4'd1) m_carry = (a < b);
        m_regs[waddr] = model_alu(func, a, b);
      end
    end
  end

  // Compare all outputs against the model once per cycle, away from the edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      logic [DW-1:0] r;
      r = model_alu(func, m_regs[raddr1], m_regs[raddr2]);
      check("cmp_isZero", {31'd0, isZero}, {31'd0, (r == 0)});
      check("cmp_aLtB",   {31'd0, aLtB},   {31'd0, (m_regs[raddr1] < m_regs[raddr2])});
      check("cmp_carry",  {31'd0, carry},  {31'd0, m_carry});
      check("cmp_dbg",    dbg_rdata,       m_regs[dbg_raddr]);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_const(input logic [AW-1:0] a, input logic [DW-1:0] v);
    wen = 1'b1; wdsrc = 1'b1; waddr = a; constant = v;
    tick();
    wen = 1'b0;
  endtask

  task automatic alu_wr(input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                        input logic [3:0] f, input logic [AW-1:0] wa);
    raddr1 = ra; raddr2 = rb; func = f;
    wen = 1'b1; wdsrc = 1'b0; waddr = wa;
    tick();
    wen = 1'b0;
  endtask

  task automatic peek(input string name, input logic [AW-1:0] a,
                      input logic [DW-1:0] exp);
    dbg_raddr = a;
    #1;
    check(name, dbg_rdata, exp);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    rst = 1'b0;
    raddr1 = '0; raddr2 = '0; waddr = '0; dbg_raddr = '0;
    wen = 1'b0; wdsrc = 1'b0; func = 4'd0; constant = '0;
    cmp_en = 1'b1;
    tick();
    tick();
    rst = 1'b1;

    // Reset contents and flags.
    for (int i = 0; i < NREG; i++) peek("reset_dbg", AW'(i), 32'd0);
    check("reset_carry",  {31'd0, carry},  32'd0);
    check("reset_isZero", {31'd0, isZero}, 32'd1);
    check("reset_aLtB",   {31'd0, aLtB},   32'd0);

    // 48 - 18 compare, then write back.
    wr_const(4'd1, 32'd48);
    wr_const(4'd2, 32'd18);
    raddr1 = 4'd1; raddr2 = 4'd2; func = 4'd1; #1;
    check("sub48_18_isZero", {31'd0, isZero}, 32'd0);
    check("sub48_18_aLtB",   {31'd0, aLtB},   32'd0);
    alu_wr(4'd1, 4'd2, 4'd1, 4'd1);
    peek("r1_is_30", 4'd1, 32'd30);
    check("carry_after_30", {31'd0, carry}, 32'd0);

    // Subtractive GCD, steered by the DUT flags.
    begin
      bool_loop: for (int it = 0; it < 64; it++) begin
        raddr1 = 4'd1; raddr2 = 4'd2; func = 4'd1; #1;
        if (isZero) break;
        if (aLtB) alu_wr(4'd2, 4'd1, 4'd1, 4'd2);
        else      alu_wr(4'd1, 4'd2, 4'd1, 4'd1);
      end
    end
    raddr1 = 4'd1; raddr2 = 4'd2; func = 4'd1; #1;
    check("gcd_final_isZero", {31'd0, isZero}, 32'd1);
    peek("gcd_r1", 4'd1, 32'd6);
    peek("gcd_r2", 4'd2, 32'd6);

    // Wrapping subtract and carrying add.
    wr_const(4'd1, 32'd5);
    wr_const(4'd2, 32'd7);
    alu_wr(4'd1, 4'd2, 4'd1, 4'd3);
    peek("sub5_7", 4'd3, 32'hFFFF_FFFE);
    check("sub5_7_borrow", {31'd0, carry}, 32'd1);
    wr_const(4'd1, 32'hFFFF_FFFF);
    wr_const(4'd2, 32'd1);
    raddr1 = 4'd1; raddr2 = 4'd2; func = 4'd0; #1;
    check("add_wrap_isZero", {31'd0, isZero}, 32'd1);
    alu_wr(4'd1, 4'd2, 4'd0, 4'd4);
    peek("add_wrap_r4", 4'd4, 32'd0);
    check("add_wrap_carry", {31'd0, carry}, 32'd1);

    // Constant writes ignore func and leave carry alone.
    raddr1 = 4'd1; raddr2 = 4'd1; func = 4'd1;
    wr_const(4'd8, 32'h1234_5678);
    peek("const_ignores_func", 4'd8, 32'h1234_5678);
    check("const_keeps_carry", {31'd0, carry}, 32'd1);

    // Same-cycle write/read: old value visible until the edge.
    wr_const(4'd5, 32'h33);
    wr_const(4'd6, 32'h50);
    raddr1 = 4'd5; raddr2 = 4'd6; func = 4'd6; dbg_raddr = 4'd5;
    wen = 1'b1; wdsrc = 1'b1; waddr = 4'd5; constant = 32'hA5; #1;
    check("same_cycle_old_dbg",  dbg_rdata, 32'h33);
    check("same_cycle_old_aLtB", {31'd0, aLtB}, 32'd1);
    tick();
    wen = 1'b0; #1;
    check("next_cycle_new_dbg",  dbg_rdata, 32'hA5);
    check("next_cycle_new_aLtB", {31'd0, aLtB}, 32'd0);

    // Reserved opcode gives zero.
    func = 4'd9; #1;
    check("func9_isZero", {31'd0, isZero}, 32'd1);

    // Reset pulse across an edge while a write is pending.
    wen = 1'b1; wdsrc = 1'b1; waddr = 4'd7; constant = 32'hDEAD;
    #2 rst = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    wen = 1'b0;
    for (int i = 0; i < NREG; i++) peek("rst_pulse_dbg", AW'(i), 32'd0);
    check("rst_pulse_carry", {31'd0, carry}, 32'd0);

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      tick();
      raddr1    = AW'($urandom_range(0, NREG - 1));
      raddr2    = AW'($urandom_range(0, NREG - 1));
      waddr     = AW'($urandom_range(0, NREG - 1));
      dbg_raddr = AW'($urandom_range(0, NREG - 1));
      wen       = ($urandom_range(0, 3) != 0);
      wdsrc     = ($urandom_range(0, 2) == 0);
      func      = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(8, 15))
                                              : 4'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: constant = 32'($urandom_range(0, 3));
        1: constant = 32'hFFFF_FFFF;
        default: constant = $urandom;
      endcase
    end
    tick();
    wen = 1'b0;
    tick();

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
